// File: rtl/mem_access_sequencer.sv
// Shares one single-port external memory between instruction fetch and load/store,
// sequencing each instruction as fetch, optional data access, then a one-cycle commit.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_to_mem,
  output logic [31:0] mem_data_from_mem,
  output logic        core_en,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_ack,
  output logic        bus_error,
  output logic        rw_conflict
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_COMMIT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_mdata;
  logic [7:0]  r_wait_cnt;
  logic        r_bus_error;
  logic        r_rw_conflict;
  logic        w_timeout;
  logic        w_mem_op;

  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));
  assign w_mem_op  = mem_read | mem_write;

  assign instruction       = r_instr;
  assign mem_data_from_mem = r_mdata;
  assign bus_error         = r_bus_error;
  assign rw_conflict       = r_rw_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Bus outputs decode from the state register alone, so they fall with rst at once.
  always_comb begin
    w_next    = r_state;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    core_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        ext_req  = 1'b1;
        ext_addr = instruction_address;
        if (ext_ack || w_timeout) w_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_mem_op) begin
          w_next = S_DATA;
        end else begin
          core_en = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_DATA: begin
        ext_req   = 1'b1;
        ext_we    = mem_write;
        ext_addr  = mem_address;
        ext_wdata = mem_data_to_mem;
        if (ext_ack || w_timeout) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        core_en = 1'b1;
        w_next  = S_FETCH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr       <= NOP_INSTR;
      r_mdata       <= '0;
      r_wait_cnt    <= '0;
      r_bus_error   <= 1'b0;
      r_rw_conflict <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (ext_ack) begin
            r_instr    <= ext_rdata;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_instr     <= NOP_INSTR;
            r_bus_error <= 1'b1;
            r_wait_cnt  <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (mem_read && mem_write) r_rw_conflict <= 1'b1;
          // Only a true load (write strobe low) touches the load-data register.
          if (ext_ack) begin
            if (!mem_write) r_mdata <= ext_rdata;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            if (!mem_write) r_mdata <= '0;
            r_bus_error <= 1'b1;
            r_wait_cnt  <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_wait_cnt <= r_wait_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: each instruction is expanded into an expected per-cycle trace from the
// latency/handshake rules, then replayed against the sequencer and compared every cycle.
module tb_mem_access_sequencer;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW      = 32'h0000_A103;
  localparam logic [31:0] SW      = 32'h0020_A023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_address = '0;
  logic [31:0] instruction;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_data_to_mem = '0;
  logic [31:0] mem_data_from_mem;
  logic        core_en;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata = '0;
  logic        ext_ack = 1'b0;
  logic        bus_error;
  logic        rw_conflict;

  mem_access_sequencer #(.TIMEOUT(TIMEOUT), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .instruction_address(instruction_address), .instruction(instruction),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_to_mem(mem_data_to_mem), .mem_data_from_mem(mem_data_from_mem),
    .core_en(core_en), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .bus_error(bus_error), .rw_conflict(rw_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] pc, maddr, mwdata, rdata;
    bit          mr, mw, ack;
    bit          e_req, e_we, e_cen, e_be, e_rwc;
    logic [31:0] e_addr, e_wdata, e_instr, e_mdata;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cen = 0;
  int   period = 0;

  logic [31:0] m_instr;
  logic [31:0] m_mdata;
  bit          m_be;
  bit          m_rwc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic cyc_t mk();
    cyc_t c;
    c.rst = 1'b0; c.pc = '0; c.maddr = '0; c.mwdata = '0; c.rdata = 32'hFFFF_FFFF;
    c.mr = 1'b0; c.mw = 1'b0; c.ack = 1'b0;
    c.e_req = 1'b0; c.e_we = 1'b0; c.e_cen = 1'b0;
    c.e_addr = '0; c.e_wdata = '0;
    c.e_instr = m_instr; c.e_mdata = m_mdata; c.e_be = m_be; c.e_rwc = m_rwc;
    return c;
  endfunction

  task automatic model_reset();
    m_instr = NOP; m_mdata = '0; m_be = 1'b0; m_rwc = 1'b0;
  endtask

  task automatic push_idle(input bit r);
    cyc_t c;
    c = mk();
    c.rst = r;
    q.push_back(c);
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store, 3 = read and write both asserted.
  // fw/dw = wait cycles before ack; a value >= TIMEOUT means no ack at all.
  task automatic add_instr(input logic [31:0] pc, input logic [31:0] iw, input int kind,
                           input logic [31:0] ma, input logic [31:0] wd, input logic [31:0] rd,
                           input int fw, input int dw, input bit stray);
    cyc_t c;
    int   n;
    bit   mr, mw;
    mr = (kind == 1 || kind == 3);
    mw = (kind >= 2);
    n  = (fw >= TIMEOUT) ? TIMEOUT : fw + 1;
    for (int k = 0; k < n; k++) begin
      c = mk();
      c.pc = pc; c.mr = mr; c.mw = mw; c.maddr = ma; c.mwdata = wd;
      c.ack = (k == fw);
      c.rdata = c.ack ? iw : (32'hBAD0_0000 | 32'(k));
      c.e_req = 1'b1; c.e_addr = pc;
      q.push_back(c);
    end
    if (fw >= TIMEOUT) begin m_instr = NOP; m_be = 1'b1; end
    else m_instr = iw;
    c = mk();
    c.pc = pc; c.mr = mr; c.mw = mw; c.maddr = ma; c.mwdata = wd;
    c.ack = stray; c.rdata = 32'h7777_7777;
    c.e_cen = (kind == 0);
    q.push_back(c);
    if (kind != 0) begin
      n = (dw >= TIMEOUT) ? TIMEOUT : dw + 1;
      for (int k = 0; k < n; k++) begin
        c = mk();
        c.pc = pc; c.mr = mr; c.mw = mw; c.maddr = ma; c.mwdata = wd;
        c.ack = (k == dw);
        c.rdata = c.ack ? rd : (32'hD00D_0000 | 32'(k));
        c.e_req = 1'b1; c.e_we = mw; c.e_addr = ma; c.e_wdata = wd;
        c.e_rwc = m_rwc | (kind == 3 && k > 0);
        q.push_back(c);
      end
      if (kind == 3) m_rwc = 1'b1;
      if (dw >= TIMEOUT) begin
        m_be = 1'b1;
        if (kind == 1) m_mdata = '0;
      end else if (kind == 1) begin
        m_mdata = rd;
      end
      c = mk();
      c.pc = pc; c.mr = mr; c.mw = mw; c.maddr = ma; c.mwdata = wd;
      c.ack = stray; c.rdata = 32'h6666_6666;
      c.e_cen = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst = c.rst; instruction_address = c.pc; mem_read = c.mr; mem_write = c.mw;
      mem_address = c.maddr; mem_data_to_mem = c.mwdata; ext_rdata = c.rdata; ext_ack = c.ack;
      @(negedge clk);
      cyc++;
      chk("ext_req", {31'b0, ext_req}, {31'b0, c.e_req});
      chk("core_en", {31'b0, core_en}, {31'b0, c.e_cen});
      chk("instruction", instruction, c.e_instr);
      chk("mem_data_from_mem", mem_data_from_mem, c.e_mdata);
      chk("bus_error", {31'b0, bus_error}, {31'b0, c.e_be});
      chk("rw_conflict", {31'b0, rw_conflict}, {31'b0, c.e_rwc});
      if (c.e_req) begin
        chk("ext_we", {31'b0, ext_we}, {31'b0, c.e_we});
        chk("ext_addr", ext_addr, c.e_addr);
        chk("ext_wdata", ext_wdata, c.e_wdata);
      end
      if (core_en === 1'b1) begin
        period   = cyc - last_cen;
        last_cen = cyc;
      end
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  initial begin
    model_reset();
    push_idle(1'b1);
    push_idle(1'b1);
    push_idle(1'b0);

    // 1: two back-to-back ALU ops with zero-wait memory
    add_instr(32'h0, 32'h0050_0093, 0, '0, '0, '0, 0, 0, 1'b0);
    add_instr(32'h4, 32'h0050_0093, 0, '0, '0, '0, 0, 0, 1'b0);
    run_all();
    chk("t1_period", period, 2);

    // 2: load with 3 wait cycles
    add_instr(32'h8, LW, 1, 32'h200, '0, 32'hDEAD_BEEF, 0, 3, 1'b0);
    run_all();
    chk("t2_period", period, 7);
    chk("t2_load_data", mem_data_from_mem, 32'hDEAD_BEEF);

    // 3: store keeps load data
    add_instr(32'hC, SW, 2, 32'h100, 32'h1234_5678, 32'h5555_5555, 1, 2, 1'b0);
    run_all();
    chk("t3_load_held", mem_data_from_mem, 32'hDEAD_BEEF);

    // 4: fetch timeout, then ack on the last allowed cycle, then a load timeout
    add_instr(32'h10, 32'h0010_0113, 0, '0, '0, '0, TIMEOUT, 0, 1'b0);
    run_all();
    chk("t4_period", period, 17);
    chk("t4_nop", instruction, 32'h0000_0013);
    chk("t4_bus_error", {31'b0, bus_error}, 32'd1);
    add_instr(32'h14, 32'h0030_0193, 0, '0, '0, '0, TIMEOUT - 1, 0, 1'b0);
    run_all();
    chk("t4_edge_instr", instruction, 32'h0030_0193);
    add_instr(32'h18, LW, 1, 32'h204, '0, 32'h1111_2222, 0, TIMEOUT, 1'b0);
    run_all();
    chk("t4_load_timeout", mem_data_from_mem, 32'h0);

    // 5: read+write together, stray acks in EXEC and COMMIT
    add_instr(32'h1C, SW, 3, 32'h300, 32'hCAFE_F00D, 32'h9999_9999, 0, 1, 1'b1);
    add_instr(32'h20, 32'h0050_0093, 0, '0, '0, '0, 0, 0, 1'b1);
    run_all();
    chk("t5_rw_conflict", {31'b0, rw_conflict}, 32'd1);

    // 6: asynchronous reset in the middle of a data access
    add_instr(32'h24, LW, 1, 32'h400, '0, 32'h4444_4444, 0, 10, 1'b0);
    run_n(4);
    @(posedge clk);
    #3;
    chk("t6_pre_req", {31'b0, ext_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_req_drop", {31'b0, ext_req}, 32'd0);
    chk("t6_cen", {31'b0, core_en}, 32'd0);
    chk("t6_be_clr", {31'b0, bus_error}, 32'd0);
    chk("t6_rwc_clr", {31'b0, rw_conflict}, 32'd0);
    chk("t6_nop", instruction, 32'h0000_0013);
    q.delete();
    model_reset();
    push_idle(1'b1);
    push_idle(1'b0);
    add_instr(32'h0, 32'h0050_0093, 0, '0, '0, '0, 0, 0, 1'b0);
    run_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Shares one external single-port memory between instruction fetch and load/store for the rv32i core.
- Sequences each instruction as fetch, then an optional data access, then commit, with a per-access timeout.
- Presents a held instruction word and load data to the core.
- Issues a one-cycle `core_en` pulse that gates the PC and register-file updates.

Parameters:
- TIMEOUT, 16, max wait cycles per memory access before abort (legal range 1..255)
- NOP_INSTR, 32'h00000013, instruction delivered on reset and on a fetch timeout (addi x0,x0,0)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- instruction_address  input  32  PC from core; fetch address
- instruction  output  32  held instruction word to core
- mem_read  input  1  core load request, decoded from `instruction`
- mem_write  input  1  core store request, decoded from `instruction`
- mem_address  input  32  core load/store address
- mem_data_to_mem  input  32  core store data
- mem_data_from_mem  output  32  held load data to core
- core_en  output  1  one-cycle commit pulse (PC and register-file write enable)
- ext_req  output  1  external memory request
- ext_we  output  1  external write strobe, valid while ext_req=1
- ext_addr  output  32  external address
- ext_wdata  output  32  external write data
- ext_rdata  input  32  external read data, sampled when ext_ack=1
- ext_ack  input  1  external completion, one cycle per access
- bus_error  output  1  sticky: a timeout occurred
- rw_conflict  output  1  sticky: mem_read and mem_write were seen high together

Behaviour:
- States: IDLE, FETCH, EXEC, DATA, COMMIT. Registered 2-bit/3-bit state; outputs decoded from state plus held registers.
- Reset (async, immediate): state=IDLE, instruction=NOP_INSTR, mem_data_from_mem=0, wait_cnt=0, core_en=0, ext_req=0, bus_error=0, rw_conflict=0. ext_req drops in the same cycle rst rises, even mid-access.
- IDLE: ext_req=0. Next state is FETCH unconditionally. The first cycle after reset release is always IDLE.
- FETCH: ext_req=1, ext_we=0, ext_addr=instruction_address, ext_wdata=0.
  - ext_ack=1: instruction<=ext_rdata, wait_cnt<=0, next EXEC.
  - no ack and wait_cnt==TIMEOUT-1: instruction<=NOP_INSTR, bus_error<=1, wait_cnt<=0, next EXEC.
  - otherwise wait_cnt<=wait_cnt+1.
- EXEC: ext_req=0. The core decodes the held instruction combinationally.
  - mem_read|mem_write: next DATA.
  - else: core_en=1 this cycle, next FETCH.
- DATA: ext_req=1, ext_addr=mem_address, ext_wdata=mem_data_to_mem.
  - ext_we=mem_write. If both mem_read and mem_write are high, the write wins and rw_conflict<=1.
  - ext_ack=1: if the access is a read (ext_we=0), mem_data_from_mem<=ext_rdata; for a store mem_data_from_mem is held. wait_cnt<=0, next COMMIT.
  - timeout (same rule as FETCH): mem_data_from_mem<=0 on a load, bus_error<=1, next COMMIT. A store is dropped.
- COMMIT: ext_req=0, core_en=1, next FETCH.
- Handshake rules:
  - ext_req, ext_we, ext_addr and ext_wdata stay stable from the first cycle of an access until ext_ack or timeout.
  - A zero-wait ack, in the same cycle ext_req rises, is legal.
  - ext_ack while ext_req=0 (IDLE/EXEC/COMMIT) is ignored and has no state effect.
- Latency with zero-wait memory:
  - non-memory instruction: 2 cycles (FETCH, EXEC).
  - load/store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - each wait cycle adds 1; TIMEOUT caps each access at TIMEOUT cycles.
- core_en is high for exactly one cycle per instruction and never in IDLE, FETCH or DATA.
- instruction and mem_data_from_mem change only on the transitions listed above.
- bus_error and rw_conflict clear only on rst.
- wait_cnt is 8 bits wide and never exceeds TIMEOUT-1.

Test Plan:
1. Reset, zero-wait memory returning 32'h00500093 (addi) at PC 0 -> ext_req rises the cycle after IDLE; instruction=32'h00500093 in EXEC; core_en pulses once; instruction period is 2 cycles.
2. Load with 3 wait cycles, ext_rdata=32'hDEADBEEF at ack -> ext_addr=mem_address held stable for 4 cycles in DATA; mem_data_from_mem=32'hDEADBEEF during COMMIT; core_en only in COMMIT; total 7 cycles.
3. Store with mem_address=32'h100 and mem_data_to_mem=32'h12345678 -> ext_we=1, ext_wdata=32'h12345678 until ack; mem_data_from_mem unchanged.
4. Fetch with no ack, TIMEOUT=16 -> after exactly 16 FETCH cycles instruction=32'h00000013, bus_error=1 (sticky); next instruction proceeds normally.
5. Force mem_read=mem_write=1 in EXEC -> DATA issues ext_we=1 and rw_conflict=1. Stray ext_ack pulses in EXEC and COMMIT cause no state change.
6. Assert rst mid-DATA with ext_req=1 -> ext_req=0 and core_en=0 in the same cycle, both sticky flags cleared, instruction=NOP_INSTR; after release the sequence is IDLE then FETCH.
